fetch_unit: RTL and testbench

//  Instruction fetch stage directly upstream of the simulation RAM instruction port. Owns the PC and drives
//  i_addr_o every cycle. Captures the 1-cycle-latency i_data_i into a 2-entry buffer and presents
//  {pc, instr, valid} to decode. Supports decode back-pressure (stall) and redirect (jump) with flush.

---
 rtl/fetch_unit_pkg.sv | 11 +
 rtl/fetch_buffer.sv | 50 +++++
 rtl/fetch_unit.sv | 84 ++++++++
 tb/tb_fetch_unit.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared types and constants for the instruction fetch stage
package fetch_unit_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0000_0013;

  typedef struct packed {
    logic [15:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_buffer.sv
// rtl/fetch_buffer.sv - 2-entry FIFO of fetched {pc, instr} pairs; head is entry 0
module fetch_buffer
  import fetch_unit_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  input  logic         push,
  input  fetch_entry_t push_data,
  input  logic         pop,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t entry0, entry1;

  always_ff @(posedge clk) begin
    if (!rst || flush) begin
      count <= 2'd0;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) entry0 <= push_data;
          else               entry1 <= push_data;
          count <= count + 2'd1;
        end
        2'b01: begin
          entry0 <= entry1;
          count  <= count - 2'd1;
        end
        2'b11: begin
          // Simultaneous push and pop keeps the occupancy; the new word lands behind the survivor
          if (count == 2'd1) begin
            entry0 <= push_data;
          end else begin
            entry0 <= entry1;
            entry1 <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = entry0;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst || flush)
                                 !(push && !pop && count == 2'd2));

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC, credit-based issue, 1-cycle RAM capture
// Optional FETCH_PERF_EN adds pop and flush counters.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] i_addr_o,
  input  logic [31:0] i_data_i,
  input  logic        stall_i,
  input  logic        jump_i,
  input  logic [15:0] jump_target_i,
  output logic        instr_valid_o,
  output logic [31:0] instr_o,
  output logic [15:0] pc_o
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] fetch_cnt_o,
  output logic [31:0] flush_cnt_o
`endif
);

  logic [15:0]  pc_q, inflight_pc, jump_pc;
  logic         inflight, pop, push, issue;
  logic [2:0]   credit;
  logic [1:0]   count;
  fetch_entry_t head, push_entry;

  assign pop        = (count != 2'd0) && !stall_i;
  assign push       = inflight && !jump_i;
  // Words already buffered plus the one on its way must leave room for the next issue
  assign credit     = {1'b0, count} + {2'b00, inflight} - {2'b00, pop};
  assign issue      = (credit < 3'd2);
  assign jump_pc    = jump_target_i & 16'hFFFC;
  assign push_entry = '{pc: inflight_pc, instr: i_data_i};

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc_q        <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= 16'h0000;
    end else if (jump_i) begin
      pc_q     <= jump_pc;
      inflight <= 1'b0;
    end else if (issue) begin
      inflight    <= 1'b1;
      inflight_pc <= pc_q;
      pc_q        <= pc_q + 16'd4;
    end else begin
      inflight <= 1'b0;
    end
  end

  fetch_buffer u_buf (
    .clk       (clk),
    .rst       (rst),
    .flush     (jump_i),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .count     (count),
    .head      (head)
  );

  assign i_addr_o      = pc_q;
  assign instr_valid_o = (count != 2'd0);
  assign instr_o       = instr_valid_o ? head.instr : INSTR_NOP;
  assign pc_o          = instr_valid_o ? head.pc : 16'h0000;

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk) begin
    if (!rst) begin
      fetch_cnt_o <= 32'd0;
      flush_cnt_o <= 32'd0;
    end else begin
      if (pop && !jump_i)                            fetch_cnt_o <= fetch_cnt_o + 32'd1;
      if (jump_i && (count != 2'd0 || inflight))     flush_cnt_o <= flush_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed bench for fetch_unit with a 1-cycle RAM model
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst, stall, jump;
  logic [15:0] target;
  logic [15:0] addr_a, addr_b, pc_a, pc_b;
  logic [31:0] data_a, data_b, instr_a, instr_b;
  logic        valid_a, valid_b;
`ifdef FETCH_PERF_EN
  logic [31:0] fcnt_a, flcnt_a, fcnt_b, flcnt_b;
`endif

  int errors = 0;
  int checks = 0;
  int pops = 0;
  int flushes = 0;
  logic prev_ev = 1'b0;

  always #5 clk = ~clk;

  fetch_unit u_dut_a (
    .clk(clk), .rst(rst), .i_addr_o(addr_a), .i_data_i(data_a),
    .stall_i(stall), .jump_i(jump), .jump_target_i(target),
    .instr_valid_o(valid_a), .instr_o(instr_a), .pc_o(pc_a)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(fcnt_a), .flush_cnt_o(flcnt_a)
`endif
  );

  fetch_unit #(.RESET_PC(16'hFFF8)) u_dut_b (
    .clk(clk), .rst(rst), .i_addr_o(addr_b), .i_data_i(data_b),
    .stall_i(stall), .jump_i(jump), .jump_target_i(target),
    .instr_valid_o(valid_b), .instr_o(instr_b), .pc_o(pc_b)
`ifdef FETCH_PERF_EN
    , .fetch_cnt_o(fcnt_b), .flush_cnt_o(flcnt_b)
`endif
  );

  always_ff @(posedge clk) begin
    data_a <= 32'hA000_0000 | {16'h0000, addr_a};
    data_b <= 32'hA000_0000 | {16'h0000, addr_b};
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock; the pop model follows the bench's own expectation of validity
  task automatic step_chk(input string tag, input logic ev, input logic [15:0] epc);
    if (rst && prev_ev && !stall && !jump) pops++;
    @(posedge clk);
    #1;
    if (!rst) pops = 0;
    chk({tag, ".valid"}, {31'd0, valid_a}, {31'd0, ev});
    if (ev) begin
      chk({tag, ".pc"}, {16'd0, pc_a}, {16'd0, epc});
      chk({tag, ".instr"}, instr_a, 32'hA000_0000 | {16'd0, epc});
    end else begin
      chk({tag, ".pc_idle"}, {16'd0, pc_a}, 32'd0);
      chk({tag, ".nop"}, instr_a, 32'h0000_0013);
    end
`ifdef FETCH_PERF_EN
    chk({tag, ".fetch_cnt"}, fcnt_a, pops);
    chk({tag, ".flush_cnt"}, flcnt_a, flushes);
`endif
    prev_ev = ev;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; jump = 1'b0; target = 16'h0000;
    @(posedge clk); @(posedge clk); #1;
    chk("rst.valid", {31'd0, valid_a}, 32'd0);
    chk("rst.instr", instr_a, 32'h0000_0013);
    chk("rst.pc", {16'd0, pc_a}, 32'd0);
    chk("rst.addr", {16'd0, addr_a}, 32'd0);
    chk("rst.addr_b", {16'd0, addr_b}, 32'h0000_FFF8);

    // Stream from reset; second instance wraps through 0xFFFC -> 0x0000
    rst = 1'b1;
    step_chk("t1.first", 1'b0, 16'h0);
    chk("t1.addr", {16'd0, addr_a}, 32'h4);
    for (int k = 0; k < 6; k++) begin
      step_chk("t1.seq", 1'b1, 16'(4 * k));
      if (k < 4) begin
        chk("t5.valid_b", {31'd0, valid_b}, 32'd1);
        chk("t5.pc_b", {16'd0, pc_b}, {16'd0, 16'hFFF8 + 16'(4 * k)});
        chk("t5.instr_b", instr_b, 32'hA000_0000 | {16'd0, 16'hFFF8 + 16'(4 * k)});
      end
    end
    chk("t1.addr_lead", {16'd0, addr_a}, 32'h1C);

    stall = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step_chk("t2.hold", 1'b1, 16'h14);
      chk("t2.addr_hold", {16'd0, addr_a}, 32'h1C);
    end
    stall = 1'b0;
    for (int k = 0; k < 4; k++) step_chk("t2.resume", 1'b1, 16'(16'h18 + 4 * k));

    // Jump with a full buffer; low target bits are dropped
    stall = 1'b1;
    step_chk("t3.fill", 1'b1, 16'h24);
    step_chk("t3.fill", 1'b1, 16'h24);
    stall = 1'b0; jump = 1'b1; target = 16'h0103; flushes++;
    step_chk("t3.jump", 1'b0, 16'h0);
    chk("t3.addr", {16'd0, addr_a}, 32'h100);
    jump = 1'b0;
    step_chk("t3.gap", 1'b0, 16'h0);
    step_chk("t3.target", 1'b1, 16'h100);
    step_chk("t3.next", 1'b1, 16'h104);
    step_chk("t3.next", 1'b1, 16'h108);

    // Jump and stall together: jump wins and empties the buffer
    jump = 1'b1; stall = 1'b1; target = 16'h0200; flushes++;
    step_chk("t4.jump", 1'b0, 16'h0);
    chk("t4.addr", {16'd0, addr_a}, 32'h200);
    jump = 1'b0;
    step_chk("t4.gap", 1'b0, 16'h0);
    step_chk("t4.target", 1'b1, 16'h200);
    step_chk("t4.hold", 1'b1, 16'h200);
    stall = 1'b0;
    step_chk("t4.resume", 1'b1, 16'h204);
    step_chk("t4.resume", 1'b1, 16'h208);

    // Reset in the middle of a stalled, full buffer
    stall = 1'b1;
    step_chk("t6.fill", 1'b1, 16'h208);
    step_chk("t6.fill", 1'b1, 16'h208);
    rst = 1'b0; flushes = 0;
    step_chk("t6.rst", 1'b0, 16'h0);
    chk("t6.addr", {16'd0, addr_a}, 32'h0);
    chk("t6.addr_b", {16'd0, addr_b}, 32'h0000_FFF8);
    rst = 1'b1; stall = 1'b0;
    step_chk("t6.restart", 1'b0, 16'h0);
    step_chk("t6.restart", 1'b1, 16'h0);
    step_chk("t6.restart", 1'b1, 16'h4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
